// File: rtl/load_store_unit.sv
// load_store_unit
// Execute-stage load/store unit. Each accepted request performs one data-memory access
// over an AXI4-lite-style port. Load data is extended and returned on lsu_result.
// lsu_done pulses for one cycle when the access completes. lsu_work stays high while
// the unit is busy, so that control can stall the pipeline.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword and word
// accesses. A trapped access goes straight to completion with lsu_err set and issues
// no bus traffic. When the macro is undefined, the low address bits are ignored and
// the access is issued at the naturally aligned address.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req, lsu_op                 start strobe (sampled only when idle);
//                               lsu_op = {is_store, unsigned, size[1:0]}
//   base, offset, store_data    rs1, sign-extended immediate, rs2
//   lsu_work, lsu_done          busy flag, one-cycle completion pulse
//   lsu_result, lsu_err         extended load data (0 for stores and errors); error flag
//                               valid with lsu_done
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [3:0]          lsu_op,
    input  logic [31:0]         base,
    input  logic [31:0]         offset,
    input  logic [DATA_W-1:0]   store_data,
    output logic                lsu_work,
    output logic                lsu_done,
    output logic [DATA_W-1:0]   lsu_result,
    output logic                lsu_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

    state_t              state, state_nx;
    logic                store_q, uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   ea_q;
    logic [DATA_W-1:0]   sd_q;
    logic                aw_done, w_done;
    logic [DATA_W-1:0]   result_q;
    logic                err_q;

    logic [31:0]         ea_sum;
    logic [ADDR_W-1:0]   ea_in;
    logic                misalign, bad_in;

    // Pick the addressed byte/halfword out of the word and sign- or zero-extend it.
    // Halfwords use only ea[1], so an unaligned halfword reads the naturally aligned lane.
    function automatic logic [31:0] ext_load(input logic [31:0] data, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lane);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        sh = data;
        s  = data;
        case (size)
            2'b00: begin
                sh = data >> {lane, 3'b000};
                b  = sh[7:0];
                s  = b;
                if (uns) s = {24'd0, sh[7:0]};
            end
            2'b01: begin
                sh = data >> {lane[1], 4'b0000};
                h  = sh[15:0];
                s  = h;
                if (uns) s = {16'd0, sh[15:0]};
            end
            default: s = data;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] strb_for(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the store operand across every lane so the strobe alone selects the bytes.
    function automatic logic [31:0] wdata_for(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign ea_sum = base + offset;
    assign ea_in  = ADDR_W'(ea_sum);

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((lsu_op[1:0] == 2'b01) && ea_in[0]) ||
                      ((lsu_op[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Reserved size and trapped accesses never touch the bus.
    assign bad_in = (lsu_op[1:0] == 2'b11) || misalign;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) begin
                if (bad_in)         state_nx = DONE;
                else if (lsu_op[3]) state_nx = WR;
                else                state_nx = RD_A;
            end
            RD_A: if (arready) state_nx = RD_D;
            RD_D: if (rvalid)  state_nx = DONE;
            // AW and W may complete in the same or in different cycles.
            WR:   if ((aw_done || awready) && (w_done || wready)) state_nx = WR_B;
            WR_B: if (bvalid)  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            store_q  <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            ea_q     <= '0;
            sd_q     <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req) begin
                    store_q <= lsu_op[3];
                    uns_q   <= lsu_op[2];
                    size_q  <= lsu_op[1:0];
                    ea_q    <= ea_in;
                    sd_q    <= store_data;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (bad_in) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end
                end
                WR: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
                RD_D: if (rvalid) begin
                    err_q    <= (rresp != 2'b00);
                    result_q <= (rresp != 2'b00) ? '0 : ext_load(rdata, size_q, uns_q, ea_q[1:0]);
                end
                WR_B: if (bvalid) begin
                    err_q    <= (bresp != 2'b00);
                    result_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign lsu_work   = (state != IDLE);
    assign lsu_done   = (state == DONE);
    assign lsu_err    = lsu_done && err_q;
    assign lsu_result = result_q;

    assign araddr  = {ea_q[ADDR_W-1:2], 2'b00};
    assign arvalid = (state == RD_A);
    assign rready  = (state == RD_D);
    assign awaddr  = {ea_q[ADDR_W-1:2], 2'b00};
    assign awvalid = (state == WR) && !aw_done;
    assign wvalid  = (state == WR) && !w_done;
    assign wdata   = wdata_for(sd_q, size_q);
    // The strobe is gated so that it reads as zero whenever no write is offered.
    assign wstrb   = wvalid ? strb_for(size_q, ea_q[1:0]) : 4'b0000;
    assign bready  = (state == WR_B);

    // store_q only records the op kind for completeness of the latched request.
    logic unused_ok;
    assign unused_ok = store_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk, rst_n, req;
    logic [3:0]  lsu_op;
    logic [31:0] base, offset, store_data;
    logic        lsu_work, lsu_done, lsu_err;
    logic [31:0] lsu_result;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_err    = 0;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lsu_op(lsu_op), .base(base), .offset(offset),
        .store_data(store_data), .lsu_work(lsu_work), .lsu_done(lsu_done),
        .lsu_result(lsu_result), .lsu_err(lsu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rresp = 0; bresp = 0; rdata = $urandom;
    endtask

    // One memory op with a responding slave. Expected values come from the address,
    // size and extension rules applied with plain arithmetic.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] b, o, sd, rd,
                          input logic [1:0] rr, br, input int ar_d, r_d, aw_d, w_d, b_d,
                          input int exp_lat);
        logic [31:0] ea, e_res, e_addr, e_wd, v;
        logic [3:0]  e_strb;
        int  lane, sz, c, lat;
        bit  st, uns, trap, nobus, e_err, done;
        int  n_ar, n_r, n_aw, n_w, n_b, cnt_ar, cnt_r, cnt_aw, cnt_w, cnt_b;
        bit  pv_ar, pv_rr, pv_aw, pv_w, pv_br, hs_ar, hs_r, hs_aw, hs_w, hs_b, r_fin, b_fin;

        ea = b + o; lane = ea % 4; sz = op[1:0]; st = op[3]; uns = op[2];
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 1 && ea[0]) || (sz == 2 && lane != 0);
`else
        trap = 0;
`endif
        nobus  = (sz == 3) || trap;
        e_addr = ea - lane;
        e_err  = nobus ? 1'b1 : (st ? (br != 0) : (rr != 0));
        e_res  = 0;
        if (!st && !e_err) begin
            if (sz == 0) begin
                v = (rd >> (8 * lane)) & 32'hFF;
                if (!uns && v >= 128) v = v + 32'hFFFFFF00;
            end else if (sz == 1) begin
                v = (rd >> (16 * (lane / 2))) & 32'hFFFF;
                if (!uns && v >= 32768) v = v + 32'hFFFF0000;
            end else v = rd;
            e_res = v;
        end
        e_strb = (sz == 0) ? 4'(1 << lane) : (sz == 1) ? 4'(3 << (2 * (lane / 2))) : 4'hF;
        e_wd   = (sz == 0) ? (sd & 32'hFF) * 32'h01010101 :
                 (sz == 1) ? (sd & 32'hFFFF) * 32'h00010001 : sd;

        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        cnt_ar = 0; cnt_r = 0; cnt_aw = 0; cnt_w = 0; cnt_b = 0;
        pv_ar = 0; pv_rr = 0; pv_aw = 0; pv_w = 0; pv_br = 0; r_fin = 0; b_fin = 0;
        done = 0; lat = 0;

        @(negedge clk);
        req = 1; lsu_op = op; base = b; offset = o; store_data = sd;
        for (c = 1; c <= 100; c++) begin
            @(negedge clk);
            // Operand inputs wander after the request; the unit must use its latched copy.
            req = 0; lsu_op = $urandom; base = $urandom; offset = $urandom; store_data = $urandom;
            hs_ar = pv_ar && arready; hs_r = pv_rr && rvalid; hs_aw = pv_aw && awready;
            hs_w = pv_w && wready; hs_b = pv_br && bvalid;
            n_ar += int'(hs_ar); n_r += int'(hs_r); n_aw += int'(hs_aw);
            n_w += int'(hs_w); n_b += int'(hs_b);
            if (lsu_done) begin done = 1; lat = c; break; end
            chk({tag, "/work"}, lsu_work, 1);
            if (pv_ar && !hs_ar) chk({tag, "/arvalid_hold"}, arvalid, 1);
            if (pv_aw && !hs_aw) chk({tag, "/awvalid_hold"}, awvalid, 1);
            if (pv_w && !hs_w)   chk({tag, "/wvalid_hold"}, wvalid, 1);
            if (arvalid) chk({tag, "/araddr"}, araddr, e_addr);
            if (awvalid) chk({tag, "/awaddr"}, awaddr, e_addr);
            if (wvalid) begin
                chk({tag, "/wdata"}, wdata, e_wd);
                chk({tag, "/wstrb"}, 32'(wstrb), 32'(e_strb));
            end
            if (arvalid) begin arready = (cnt_ar >= ar_d); cnt_ar++; end else arready = 0;
            if (awvalid) begin awready = (cnt_aw >= aw_d); cnt_aw++; end else awready = 0;
            if (wvalid)  begin wready  = (cnt_w >= w_d);   cnt_w++;  end else wready = 0;
            if (hs_r) begin rvalid = 0; r_fin = 1; end
            if (n_ar > 0 && !r_fin && !rvalid) begin
                if (cnt_r >= r_d) begin rvalid = 1; rdata = rd; rresp = rr; end
                else begin cnt_r++; rdata = $urandom; end
            end
            if (hs_b) begin bvalid = 0; b_fin = 1; end
            if (n_aw > 0 && n_w > 0 && !b_fin && !bvalid) begin
                if (cnt_b >= b_d) begin bvalid = 1; bresp = br; end else cnt_b++;
            end
            pv_ar = arvalid; pv_rr = rready; pv_aw = awvalid; pv_w = wvalid; pv_br = bready;
        end
        if (!done) chk({tag, "/timeout"}, 0, 1);
        else begin
            chk({tag, "/result"}, lsu_result, e_res);
            chk({tag, "/err"}, lsu_err, e_err);
            chk({tag, "/work_at_done"}, lsu_work, 1);
            chk({tag, "/n_ar"}, n_ar, (!st && !nobus) ? 1 : 0);
            chk({tag, "/n_r"}, n_r, (!st && !nobus) ? 1 : 0);
            chk({tag, "/n_aw"}, n_aw, (st && !nobus) ? 1 : 0);
            chk({tag, "/n_w"}, n_w, (st && !nobus) ? 1 : 0);
            chk({tag, "/n_b"}, n_b, (st && !nobus) ? 1 : 0);
            if (exp_lat > 0) chk({tag, "/latency"}, lat, exp_lat);
        end
        slave_idle();
        @(negedge clk);
        chk({tag, "/done_pulse"}, lsu_done, 0);
        chk({tag, "/idle_work"}, lsu_work, 0);
        chk({tag, "/result_held"}, lsu_result, e_res);
    endtask

    initial begin
        logic [3:0]  op;
        logic [1:0]  rr, br;
        rst_n = 0; req = 0; lsu_op = 0; base = 0; offset = 0; store_data = 0;
        slave_idle();
        repeat (2) @(negedge clk);
        chk("rst/work", lsu_work, 0);     chk("rst/done", lsu_done, 0);
        chk("rst/result", lsu_result, 0); chk("rst/err", lsu_err, 0);
        chk("rst/arvalid", arvalid, 0);   chk("rst/rready", rready, 0);
        chk("rst/awvalid", awvalid, 0);   chk("rst/wvalid", wvalid, 0);
        chk("rst/bready", bready, 0);     chk("rst/wstrb", 32'(wstrb), 0);
        chk("rst/araddr", araddr, 0);     chk("rst/awaddr", awaddr, 0);
        rst_n = 1;

        //       tag        op       base          offset        store_data    rdata         rr  br  ar r aw w b  lat
        run_op("lw",       4'b0010, 32'h100,      32'h4,        32'h0,        32'hDEADBEEF, 0,  0,  0, 0, 0, 0, 0, 3);
        run_op("lb",       4'b0000, 32'h100,      32'h3,        32'h0,        32'h80FFFFFF, 0,  0,  0, 0, 0, 0, 0, 3);
        run_op("lbu",      4'b0100, 32'h100,      32'h3,        32'h0,        32'h80FFFFFF, 0,  0,  0, 0, 0, 0, 0, 3);
        run_op("lh_hi",    4'b0001, 32'h400,      32'h2,        32'h0,        32'h80017FFF, 0,  0,  0, 0, 0, 0, 0, 3);
        run_op("lhu_lo",   4'b0101, 32'h400,      32'h0,        32'h0,        32'h1234ABCD, 0,  0,  0, 0, 0, 0, 0, 3);
        run_op("sh",       4'b1001, 32'h200,      32'h2,        32'h1234,     32'h0,        0,  0,  0, 0, 0, 0, 0, 3);
        run_op("sb",       4'b1000, 32'h200,      32'h1,        32'hA5,       32'h0,        0,  0,  0, 0, 0, 0, 0, 3);
        run_op("sw_slow",  4'b1010, 32'h300,      32'h0,        32'hCAFEBABE, 32'h0,        0,  0,  0, 0, 0, 3, 5, 0);
        run_op("lw_slow",  4'b0010, 32'h1000,     32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 0,  0,  2, 4, 0, 0, 0, 9);
        run_op("lw_mis",   4'b0010, 32'h100,      32'h1,        32'h0,        32'hCAFEF00D, 0,  0,  0, 0, 0, 0, 0, 0);
        run_op("sh_mis",   4'b1001, 32'h200,      32'h3,        32'h5678,     32'h0,        0,  0,  0, 0, 0, 0, 0, 0);
        run_op("rsvd",     4'b0011, 32'h100,      32'h0,        32'h0,        32'h11111111, 0,  0,  0, 0, 0, 0, 0, 1);
        run_op("rresp",    4'b0010, 32'h100,      32'h8,        32'h0,        32'h12345678, 2,  0,  0, 0, 0, 0, 0, 3);
        run_op("bresp",    4'b1010, 32'h100,      32'h8,        32'h9,        32'h0,        0,  3,  0, 0, 2, 0, 1, 0);

        // Asynchronous reset while waiting for read data.
        @(negedge clk);
        req = 1; lsu_op = 4'b0010; base = 32'h300; offset = 0;
        @(negedge clk);
        req = 0; arready = 1;
        @(negedge clk);
        arready = 0;
        chk("rstmid/rready_pre", rready, 1);
        #2 rst_n = 0;
        #1;
        chk("rstmid/arvalid", arvalid, 0);
        chk("rstmid/rready", rready, 0);
        chk("rstmid/work", lsu_work, 0);
        chk("rstmid/result", lsu_result, 0);
        @(negedge clk);
        rst_n = 1;
        run_op("after_rst", 4'b0010, 32'h40, 32'h0, 32'h0, 32'h76543210, 0, 0, 0, 0, 0, 0, 0, 3);

        for (int i = 0; i < 40; i++) begin
            op = {1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2))};
            rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_op("rand", op, $urandom, $urandom, $urandom, $urandom, rr, br,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
